// File: rtl/rot_cordic_seq.sv
// Sequencer for the iterative rotation-mode CORDIC: loads a sample, runs ITER
// feedback micro-rotations, then holds the result behind a valid/ready output.
module rot_cordic_seq #(
    parameter int ITER  = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             z_msb,
    output logic             sel,
    output logic             stage_ce,
    output logic [CNT_W-1:0] shift,
    output logic             dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready && en.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        sel         = 1'b0;
        stage_ce    = 1'b0;
        shift       = '0;
        dir         = 1'b0;
        busy        = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = en;
                stage_ce = en && in_valid;
                if (en && in_valid) begin
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                sel      = 1'b1;
                stage_ce = en;
                shift    = cnt_q;
                dir      = ~z_msb;
                busy     = 1'b1;
                if (en) begin
                    if (cnt_q == LAST) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                in_ready = en && out_ready;
                // Result registers stay frozen until the consumer takes the result.
                if (en && out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        stage_ce = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_ITER;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rot_cordic_seq.sv
// Randomized self-checking bench for rot_cordic_seq against a transaction-level
// expectation of shift/dir sequences, latency and output pulse timing.
module tb_rot_cordic_seq;

    localparam int ITER  = 12;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, en, in_valid, z_msb, out_ready;
    logic             in_ready, sel, stage_ce, dir, out_valid, busy;
    logic [CNT_W-1:0] shift;
    logic [1:0]       dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    rot_cordic_seq #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .z_msb(z_msb), .sel(sel), .stage_ce(stage_ce), .shift(shift), .dir(dir),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; z_msb = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; z_msb = 1'b0;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL reset_hold ov=%b busy=%b exp ov=0 busy=0", out_valid, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        got = {busy, sel, stage_ce, in_ready, out_valid};
        vec_cnt++;
        if (got !== 5'b00010 || shift !== '0) begin
            err_cnt++; $display("FAIL reset_release flags=%b shift=%0d exp flags=00010 shift=0", got, shift);
        end
    endtask

    task automatic test_idle_disabled();
        logic [4:0] got;
        en = 1'b0; in_valid = 1'b1;
        #1;
        got = {busy, sel, stage_ce, in_ready, out_valid};
        vec_cnt++;
        if (got !== 5'b00000) begin
            err_cnt++; $display("FAIL idle_en0 flags=%b exp=00000", got);
        end
        tick();
        in_valid = 1'b0; en = 1'b1;
        #1;
        got = {busy, sel, stage_ce, in_ready, out_valid};
        vec_cnt++;
        if (got !== 5'b00010) begin
            err_cnt++; $display("FAIL idle_no_accept flags=%b exp=00010", got);
        end
        tick();
    endtask

    // One sample from IDLE through DONE. zmode: 0 = z always 0, 1 = z high on even i, 2 = random.
    task automatic run_sample(input string name, input int stall_at, input int stall_len,
                              input int bp_len, input int zmode, input bit b2b);
        logic [4:0] got;
        logic       z;
        int         t0, lat;
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1; z_msb = 1'($urandom_range(0, 1));
        #1;
        got = {busy, sel, stage_ce, in_ready, out_valid};
        vec_cnt++;
        if (got !== 5'b00110) begin
            err_cnt++; $display("FAIL %s accept flags=%b exp=00110", name, got);
        end
        t0 = cyc;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < ITER; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    en = 1'b0; z_msb = 1'($urandom_range(0, 1));
                    #1;
                    got = {busy, sel, stage_ce, in_ready, out_valid};
                    vec_cnt++;
                    if (got !== 5'b11000 || shift !== CNT_W'(k)) begin
                        err_cnt++;
                        $display("FAIL %s stall k=%0d flags=%b shift=%0d exp flags=11000 shift=%0d",
                                 name, k, got, shift, k);
                    end
                    tick();
                end
                en = 1'b1;
            end
            z = (zmode == 0) ? 1'b0 : (zmode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            z_msb = z;
            #1;
            got = {busy, sel, stage_ce, in_ready, out_valid};
            vec_cnt++;
            if (got !== 5'b11100 || shift !== CNT_W'(k) || dir !== !z) begin
                err_cnt++;
                $display("FAIL %s iter k=%0d flags=%b shift=%0d dir=%b exp flags=11100 shift=%0d dir=%b",
                         name, k, got, shift, dir, k, !z);
            end
            tick();
        end
        lat = cyc - t0 - 1;
        vec_cnt++;
        if (lat !== ITER + stall_len || out_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s latency got=%0d ov=%b exp=%0d ov=1", name, lat, out_valid, ITER + stall_len);
        end
        for (int b = 0; b < bp_len; b++) begin
            out_ready = 1'b0; in_valid = 1'($urandom_range(0, 1)); z_msb = 1'($urandom_range(0, 1));
            #1;
            got = {busy, sel, stage_ce, in_ready, out_valid};
            vec_cnt++;
            if (got !== 5'b00001 || shift !== '0) begin
                err_cnt++; $display("FAIL %s hold b=%0d flags=%b shift=%0d exp flags=00001 shift=0",
                                    name, b, got, shift);
            end
            tick();
        end
        out_ready = 1'b1; in_valid = b2b;
        #1;
        got = {busy, sel, stage_ce, in_ready, out_valid};
        vec_cnt++;
        if (got !== (b2b ? 5'b00111 : 5'b00011)) begin
            err_cnt++; $display("FAIL %s release flags=%b exp=%b", name, got, b2b ? 5'b00111 : 5'b00011);
        end
        tick();
        in_valid = 1'b0;
        #1;
        got = {busy, sel, stage_ce, in_ready, out_valid};
        vec_cnt++;
        if (got !== (b2b ? 5'b11100 : 5'b00010) || shift !== '0) begin
            err_cnt++; $display("FAIL %s after_release flags=%b shift=%0d exp flags=%b shift=0",
                                name, got, shift, b2b ? 5'b11100 : 5'b00010);
        end
        if (b2b) apply_reset();
    endtask

    task automatic test_reset_mid();
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #1;
        vec_cnt++;
        if (shift !== CNT_W'(5) || busy !== 1'b1) begin
            err_cnt++; $display("FAIL rst_mid_pre shift=%0d busy=%b exp shift=5 busy=1", shift, busy);
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || shift !== '0) begin
            err_cnt++; $display("FAIL rst_mid busy=%b ov=%b shift=%0d exp 0 0 0", busy, out_valid, shift);
        end
        tick();
        rst_n = 1'b1;
        #1;
        vec_cnt++;
        if (in_ready !== 1'b1 || stage_ce !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL rst_mid_release rdy=%b ce=%b busy=%b exp 1 0 0", in_ready, stage_ce, busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        int accepted, c0;
        accepted = 0; c0 = 0;
        en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 4 * (ITER + 1) + 10; c++) begin
            z_msb = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                if (accepted == 0) c0 = c;
                accepted++;
            end
            if (out_valid) obs_q.push_back(32'(c));
            tick();
            if (accepted >= 4) in_valid = 1'b0;
        end
        for (int n = 0; n < 4; n++) exp_q.push_back(32'(c0 + (ITER + 1) * (n + 1)));
        vec_cnt++;
        if (accepted !== 4 || obs_q.size() !== 4) begin
            err_cnt++; $display("FAIL b2b_count accepted=%0d pulses=%0d exp 4 4", accepted, obs_q.size());
        end
        for (int n = 0; n < 4 && n < obs_q.size(); n++) begin
            vec_cnt++;
            if (obs_q[n] !== exp_q[n]) begin
                err_cnt++; $display("FAIL b2b_pulse n=%0d cycle=%0d exp=%0d", n, obs_q[n], exp_q[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_disabled();
        run_sample("single",    ITER, 0, 0, 0, 1'b0);
        run_sample("direction", ITER, 0, 0, 1, 1'b0);
        run_sample("stall",     4,    3, 0, 2, 1'b0);
        run_sample("backpress", ITER, 0, 5, 2, 1'b1);
        test_reset_mid();
        for (int r = 0; r < 6; r++)
            run_sample("random", $urandom_range(0, ITER - 1), $urandom_range(0, 4),
                       $urandom_range(0, 6), 2, 1'($urandom_range(0, 1)));
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rot_cordic_seq.md
Name: rot_cordic_seq

Overview:
- Sequencer for the iterative rotation-mode CORDIC in the QAM-16 receiver derotator.
- Drives the select and clock-enable of the x/y/z stage registers: load on accept, feedback for ITER cycles, then hold.
- Supplies the per-iteration shift/atan-ROM index and the rotation direction taken from the z-register MSB.
- Wraps the core in valid/ready handshakes on both sides, with a global stall input.

Parameters:
- ITER, 12, number of micro-rotations per sample (2..2^CNT_W).
- CNT_W, 4, width of the iteration counter and shift output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 freezes the sequencer
- in_valid  in  1  new x/y/z sample present at the stage-register load inputs
- in_ready  out  1  sample accepted on the edge where in_valid && in_ready
- z_msb  in  1  MSB (sign) of the z stage-register output
- sel  out  1  stage-register mux select: 0 = load new sample, 1 = feedback
- stage_ce  out  1  clock enable for all x/y/z stage registers
- shift  out  CNT_W  current iteration index i; shift amount and atan-ROM address
- dir  out  1  1 = rotate positive (z >= 0, subtract atan), 0 = rotate negative
- out_valid  out  1  stage registers hold a finished result
- out_ready  in  1  downstream accepts the result
- busy  out  1  high in ITER state

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE, cnt = 0, out_valid = 0. After release: in_ready = 1 (if en = 1), stage_ce = 0, sel = 0, shift = 0, busy = 0.
- Registered: state, cnt, out_valid. Combinational decode: in_ready, sel, stage_ce, shift, dir, busy.
- IDLE:
  - in_ready = en.
  - sel = 0, stage_ce = en && in_valid.
  - On an accept edge: cnt <= 0, state <= ITER.
- ITER:
  - in_ready = 0, sel = 1, stage_ce = en, shift = cnt, dir = ~z_msb, busy = 1.
  - Each enabled edge: if cnt == ITER-1, state <= DONE and out_valid <= 1; otherwise cnt <= cnt+1.
- DONE:
  - out_valid = 1, stage_ce = 0 (result held stable), sel = 0, shift = 0.
  - in_ready = en && out_ready.
  - On an enabled edge with out_ready = 1:
    - If in_valid = 1: stage_ce = 1 in that cycle (back-to-back load), cnt <= 0, state <= ITER, out_valid <= 0.
    - Otherwise: state <= IDLE, out_valid <= 0.
  - out_valid and the held result must not change while out_ready = 0.
- en = 0 in any state:
  - No state, cnt or out_valid update; stage_ce = 0; in_ready = 0.
  - out_valid keeps its value, but no transfer completes while en = 0.
- Latency and throughput:
  - Accept edge at T0: the first feedback edge is T0+1, the last is T0+ITER, and out_valid is high from T0+ITER (edge-relative).
  - Back-to-back throughput is one sample per ITER+1 cycles.
- Reset mid-operation: abandons the iteration immediately and returns to IDLE; the partial result is discarded (out_valid = 0).
- shift equals cnt in ITER only and is 0 elsewhere. cnt never exceeds ITER-1.
- z_msb is only sampled as dir during ITER; it is ignored otherwise.

Test Plan:
- Reset/idle: assert rst_n low mid-ITER at cnt = 5 -> same cycle state IDLE, out_valid = 0, busy = 0; after release in_ready = 1, stage_ce = 0.
- Single sample (ITER = 12, z_msb = 0, out_ready = 1): in_valid pulse accepted at edge 0 -> 12 cycles with sel = 1, stage_ce = 1, shift = 0..11, dir = 1; out_valid = 1 after edge 12 for exactly one cycle.
- Direction tracking: z_msb driven 1 on even iterations and 0 on odd -> dir = 0, 1, 0, 1, ... aligned per cycle with shift.
- Back-pressure: out_ready = 0 for 5 cycles after completion -> out_valid stays 1, stage_ce = 0, in_ready = 0. Then out_ready = 1 with in_valid = 1 -> sel = 0, stage_ce = 1 that cycle, next cycle shift = 0 and busy = 1.
- Stall: en = 0 for 3 cycles at shift = 4 -> shift stays 4, stage_ce = 0, no state change; resumes at 5; out_valid is delayed by exactly 3 cycles (15 after accept).
- Back-to-back stream: 4 samples with in_valid held high and out_ready = 1 -> 4 out_valid pulses spaced 13 cycles apart; no sample lost or duplicated.
